// File: rtl/midi_pkg.sv
// Shared MIDI byte classes, arbiter states and the status-byte length table.
package midi_pkg;

    typedef enum logic [1:0] {CLS_RT, CLS_STAT, CLS_DATA} byte_class_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MSG, ST_SYSEX, ST_INSERT} state_e;

    // Status bytes always have bit 7 set, so zero can mean "no running status".
    localparam logic [7:0] NO_STATUS = 8'h00;

    // Returns {sysex, data-byte count} for a status byte; zero for anything else.
    function automatic logic [2:0] midi_len(input logic [7:0] status);
        logic [2:0] r;
        r = 3'b000;
        if (status[7]) begin
            if (status < 8'hC0)      r = 3'd2;
            else if (status < 8'hE0) r = 3'd1;
            else if (status < 8'hF0) r = 3'd2;
            else begin
                case (status)
                    8'hF0:        r = 3'b100;
                    8'hF1, 8'hF3: r = 3'd1;
                    8'hF2:        r = 3'd2;
                    default:      r = 3'd0;
                endcase
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational decode of one requester byte into class, data length and SysEx flag.
module midi_byte_classifier
    import midi_pkg::*;
(
    input  logic [7:0]  data_i,
    output byte_class_e class_o,
    output logic [1:0]  len_o,
    output logic        sysex_o
);

    logic [2:0] lc;

    always_comb begin
        lc      = midi_len(data_i);
        sysex_o = lc[2];
        len_o   = lc[1:0];
        if (data_i >= 8'hF8)  class_o = CLS_RT;
        else if (data_i[7])   class_o = CLS_STAT;
        else                  class_o = CLS_DATA;
    end

endmodule

// File: rtl/midi_tx_arbiter.sv
// Two-requester MIDI transmit arbiter: message-granular locking, realtime cut-in,
// running-status tracking with status re-insertion, and a stall timeout.
module midi_tx_arbiter
    import midi_pkg::*;
#(
    parameter int TIMEOUT = 107385,
    parameter int TW      = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid_i,
    input  logic [15:0] req_data_i,
    output logic [1:0]  req_ready_o,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    input  logic        out_ready_i,
    output logic [1:0]  owner_o,
    output logic        abort_o
);

    // state     | meaning
    // ST_IDLE   | unlocked, granting round-robin
    // ST_MSG    | owner locked, cnt_q data bytes remaining
    // ST_SYSEX  | owner locked inside F0..F7
    // ST_INSERT | emitting owner's stored status ahead of its data byte

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        owner_q, owner_d;
    logic              rr_q, rr_d;
    logic [7:0]        run_q, run_d;
    logic [1:0][7:0]   stored_q, stored_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              abort_q, abort_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;

    logic [1:0][7:0]   req_byte;
    byte_class_e       cls [2];
    logic [1:0]        req_len [2];
    logic              req_sx [2];

    logic [1:0]        ready;
    logic              emit, take_stat, sel, grant, own, slot_free;
    logic [7:0]        emit_byte, acc_byte;
    logic [2:0]        ins_len;

    assign req_byte = req_data_i;

    for (genvar i = 0; i < 2; i++) begin : g_cls
        midi_byte_classifier u_cls (
            .data_i  (req_byte[i]),
            .class_o (cls[i]),
            .len_o   (req_len[i]),
            .sysex_o (req_sx[i])
        );
    end

    assign slot_free = !out_valid_q || out_ready_i;
    assign own       = owner_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        run_d       = run_q;
        stored_d    = stored_q;
        tmr_d       = tmr_q;
        abort_d     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ready       = 2'b00;
        emit        = 1'b0;
        emit_byte   = 8'h00;
        take_stat   = 1'b0;
        sel         = 1'b0;
        ins_len     = 3'b000;
        acc_byte    = 8'h00;
        grant       = rr_q ? req_valid_i[1] : !req_valid_i[0];

        if (slot_free) begin
            if (req_valid_i[0] && cls[0] == CLS_RT) begin
                ready[0]  = 1'b1;
                emit      = 1'b1;
                emit_byte = req_byte[0];
            end else if (req_valid_i[1] && cls[1] == CLS_RT) begin
                ready[1]  = 1'b1;
                emit      = 1'b1;
                emit_byte = req_byte[1];
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (req_valid_i[grant]) begin
                            if (cls[grant] == CLS_STAT) begin
                                take_stat = 1'b1;
                                sel       = grant;
                            end else if (stored_q[grant] == NO_STATUS) begin
                                ready[grant] = 1'b1;
                            end else if (run_q == stored_q[grant]) begin
                                ready[grant] = 1'b1;
                                emit         = 1'b1;
                                emit_byte    = req_byte[grant];
                                ins_len      = midi_len(stored_q[grant]);
                                if (ins_len == 3'd1) begin
                                    rr_d = !grant;
                                end else begin
                                    state_d = ST_MSG;
                                    cnt_d   = ins_len[1:0] - 2'd1;
                                    owner_d = {grant, !grant};
                                end
                            end else begin
                                state_d = ST_INSERT;
                                owner_d = {grant, !grant};
                            end
                        end
                    end
                    ST_INSERT: begin
                        emit      = 1'b1;
                        emit_byte = stored_q[own];
                        ins_len   = midi_len(stored_q[own]);
                        cnt_d     = ins_len[1:0];
                        state_d   = ST_MSG;
                    end
                    ST_MSG, ST_SYSEX: begin
                        if (req_valid_i[own]) begin
                            if (cls[own] == CLS_STAT) begin
                                take_stat = 1'b1;
                                sel       = own;
                            end else begin
                                ready[own] = 1'b1;
                                emit       = 1'b1;
                                emit_byte  = req_byte[own];
                                if (state_q == ST_MSG) begin
                                    if (cnt_q <= 2'd1) begin
                                        state_d = ST_IDLE;
                                        owner_d = 2'b00;
                                        rr_d    = !own;
                                    end else begin
                                        cnt_d = cnt_q - 2'd1;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // F7 and the other zero-length statuses complete a message on their own.
            if (take_stat) begin
                ready[sel] = 1'b1;
                emit       = 1'b1;
                emit_byte  = req_byte[sel];
                if (req_sx[sel]) begin
                    state_d = ST_SYSEX;
                    owner_d = {sel, !sel};
                end else if (req_len[sel] == 2'd0) begin
                    state_d = ST_IDLE;
                    owner_d = 2'b00;
                    rr_d    = !sel;
                end else begin
                    state_d = ST_MSG;
                    cnt_d   = req_len[sel];
                    owner_d = {sel, !sel};
                end
            end
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_byte;
            if (emit_byte >= 8'h80 && emit_byte < 8'hF0)      run_d = emit_byte;
            else if (emit_byte >= 8'hF0 && emit_byte < 8'hF8) run_d = NO_STATUS;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        for (int i = 0; i < 2; i++) begin
            acc_byte = req_byte[i];
            if (ready[i]) begin
                if (acc_byte >= 8'h80 && acc_byte < 8'hF0)      stored_d[i] = acc_byte;
                else if (acc_byte >= 8'hF0 && acc_byte < 8'hF8) stored_d[i] = NO_STATUS;
            end
        end

        if (state_q == ST_MSG || state_q == ST_SYSEX) begin
            if (req_valid_i[own]) begin
                if (ready[own]) tmr_d = '0;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                abort_d = 1'b1;
                state_d = ST_IDLE;
                owner_d = 2'b00;
                run_d   = NO_STATUS;
                rr_d    = !own;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end else begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            owner_q     <= 2'b00;
            rr_q        <= 1'b0;
            run_q       <= NO_STATUS;
            stored_q    <= '0;
            tmr_q       <= '0;
            abort_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            run_q       <= run_d;
            stored_q    <= stored_d;
            tmr_q       <= tmr_d;
            abort_q     <= abort_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign req_ready_o = ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign owner_o     = owner_q;
    assign abort_o     = abort_q;

endmodule
